// File: rtl/taillights_pkg.sv
// Shared types, sequence lengths and arbitration helpers for the taillight sequencer.
// Optional hazard preemption is enabled with TAILLIGHTS_HAZARD_PREEMPT_EN (see taillights_ctrl).
package taillights_pkg;

  typedef enum logic [1:0] {MODE_OFF, MODE_LEFT, MODE_RIGHT, MODE_HAZARD} mode_t;

  localparam int SEQ_LEN_TURN = 4;
  localparam int SEQ_LEN_HAZ  = 2;

  // Both turn requests together are treated as a hazard request.
  function automatic mode_t arb(input logic left, input logic right, input logic hazard);
    mode_t m;
    if (hazard || (left && right)) m = MODE_HAZARD;
    else if (left)                 m = MODE_LEFT;
    else if (right)                m = MODE_RIGHT;
    else                           m = MODE_OFF;
    return m;
  endfunction

  function automatic logic [1:0] last_phase(input mode_t m);
    logic [1:0] p;
    if (m == MODE_HAZARD) p = 2'(SEQ_LEN_HAZ - 1);
    else                  p = 2'(SEQ_LEN_TURN - 1);
    return p;
  endfunction

endpackage

// File: rtl/taillights_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, clears to 0 when disabled.
// tick is a decode of the registered count, gated by en.
module taillights_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_cnt <= '0;
    else if (!en || r_cnt == CNT_LAST)  r_cnt <= '0;
    else                                r_cnt <= r_cnt + CW'(1);
  end

  assign tick = en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/taillights_ctrl.sv
// Taillight sequencing controller: arbitrates requests into a mode and paces step/frame pulses.
// Define TAILLIGHTS_HAZARD_PREEMPT_EN to let hazard cut a turn sequence at the next step.
module taillights_ctrl
  import taillights_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       hazard_i,
  output mode_t      mode_o,
  output logic       step_o,
  output logic [1:0] phase_o,
  output logic       frame_o
);

  mode_t      r_mode;
  mode_t      w_mode_nxt;
  mode_t      w_arb;
  logic [1:0] r_phase;
  logic [1:0] w_phase_nxt;
  logic       w_active;
  logic       w_step;
  logic       w_last;
  logic       w_preempt;
  logic       w_frame;

  assign w_active = (r_mode != MODE_OFF);

  taillights_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_active),
    .tick (w_step)
  );

  assign w_arb  = arb(left_i, right_i, hazard_i);
  assign w_last = (r_phase == last_phase(r_mode));

`ifdef TAILLIGHTS_HAZARD_PREEMPT_EN
  assign w_preempt = (w_arb == MODE_HAZARD) &&
                     (r_mode == MODE_LEFT || r_mode == MODE_RIGHT);
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_OFF;
      r_phase <= '0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Mode only changes from OFF or on a step edge that ends a sequence (or preempts it).
  always_comb begin
    w_mode_nxt  = r_mode;
    w_phase_nxt = r_phase;
    w_frame     = 1'b0;
    if (r_mode == MODE_OFF) begin
      w_mode_nxt  = w_arb;
      w_phase_nxt = '0;
    end else if (w_step) begin
      if (w_preempt) begin
        w_mode_nxt  = MODE_HAZARD;
        w_phase_nxt = '0;
      end else if (w_last) begin
        w_mode_nxt  = w_arb;
        w_phase_nxt = '0;
        w_frame     = 1'b1;
      end else begin
        w_phase_nxt = r_phase + 2'd1;
      end
    end
  end

  assign mode_o  = r_mode;
  assign step_o  = w_step;
  assign phase_o = r_phase;
  assign frame_o = w_frame;

endmodule

// File: tb/tb_taillights_ctrl.sv
// Directed bench for taillights_ctrl at TICK_DIV=4; cycle k counts negedges after the request edge.
module tb_taillights_ctrl;
  import taillights_pkg::*;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left_i = 1'b0;
  logic       right_i = 1'b0;
  logic       hazard_i = 1'b0;
  mode_t      mode_o;
  logic       step_o;
  logic [1:0] phase_o;
  logic       frame_o;

  logic [5:0] obs;
  logic [5:0] exp_v;
  int checks = 0;
  int errors = 0;

  taillights_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .left_i   (left_i),
    .right_i  (right_i),
    .hazard_i (hazard_i),
    .mode_o   (mode_o),
    .step_o   (step_o),
    .phase_o  (phase_o),
    .frame_o  (frame_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  assign obs = {mode_o, step_o, phase_o, frame_o};

  task automatic do_reset;
    left_i = 1'b0; right_i = 1'b0; hazard_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", obs, 6'b000000);
    end
    rst = 1'b0;
  endtask

  // Full LEFT sequence, start of the next one, then an asynchronous reset mid-sequence.
  task automatic test_left_and_async_reset;
    do_reset();
    left_i = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_v = {MODE_LEFT, (k % 4 == 0), 2'(((k - 1) / 4) % 4), (k == 16)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL left k=%0d got %b exp %b", k, obs, exp_v);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL async_reset got %b exp %b", obs, 6'b000000);
    end
    left_i = 1'b0;
    #1 rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== 6'b000000) begin
        errors++;
        $display("FAIL after_reset k=%0d got %b exp %b", k, obs, 6'b000000);
      end
    end
  endtask

  task automatic test_release;
    do_reset();
    left_i = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k <= 16) exp_v = {MODE_LEFT, (k % 4 == 0), 2'((k - 1) / 4), (k == 16)};
      else         exp_v = 6'b000000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL release k=%0d got %b exp %b", k, obs, exp_v);
      end
      if (k == 10) left_i = 1'b0;
    end
  endtask

  task automatic test_hazard_pair;
    do_reset();
    left_i = 1'b1; right_i = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k <= 16) exp_v = {MODE_HAZARD, (k % 4 == 0), 2'(((k - 1) / 4) % 2), (k % 8 == 0)};
      else         exp_v = 6'b000000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hazard_pair k=%0d got %b exp %b", k, obs, exp_v);
      end
      if (k == 16) begin left_i = 1'b0; right_i = 1'b0; end
    end
  endtask

  // Hazard raised while LEFT is at phase 1.
  task automatic test_hazard_during_left;
    do_reset();
    left_i = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
`ifdef TAILLIGHTS_HAZARD_PREEMPT_EN
      if (k <= 8) exp_v = {MODE_LEFT, (k % 4 == 0), 2'((k - 1) / 4), 1'b0};
      else        exp_v = {MODE_HAZARD, (k % 4 == 0), 2'(((k - 9) / 4) % 2), (k % 8 == 0)};
`else
      if (k <= 16) exp_v = {MODE_LEFT, (k % 4 == 0), 2'((k - 1) / 4), (k == 16)};
      else         exp_v = {MODE_HAZARD, (k % 4 == 0), 2'(((k - 17) / 4) % 2), (k == 24)};
`endif
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL hazard_during_left k=%0d got %b exp %b", k, obs, exp_v);
      end
      if (k == 5) hazard_i = 1'b1;
    end
  endtask

  // LEFT hands over to RIGHT at the boundary with unbroken step cadence.
  task automatic test_back_to_back;
    do_reset();
    left_i = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k <= 16)      exp_v = {MODE_LEFT, (k % 4 == 0), 2'((k - 1) / 4), (k == 16)};
      else if (k <= 32) exp_v = {MODE_RIGHT, (k % 4 == 0), 2'((k - 17) / 4), (k == 32)};
      else              exp_v = 6'b000000;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL back_to_back k=%0d got %b exp %b", k, obs, exp_v);
      end
      if (k == 10) begin left_i = 1'b0; right_i = 1'b1; end
      if (k == 32) right_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_left_and_async_reset();
    test_release();
    test_hazard_pair();
    test_hazard_during_left();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
